// File: rtl/mac_accumulator_if.sv
// ---------------------------------------------------------------------------
// | mac_accumulator_if                                                       |
// | Term handshake and result bus between a producer and mac_accumulator.    |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

interface mac_accumulator_if #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 5
);
  logic [15:0]      product;
  logic             valid;
  logic             last;
  logic             clear;
  logic             ack;
  logic             ready;
  logic [ACC_W-1:0] accum;
  logic [CNT_W-1:0] count;
  logic             done;
  logic             overflow;

  modport master (
    output product, valid, last, clear, ack,
    input  ready, accum, count, done, overflow
  );

  modport slave (
    input  product, valid, last, clear, ack,
    output ready, accum, count, done, overflow
  );
endinterface

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// | mac_accumulator                                                          |
// | Saturating multiply-accumulate sum of 16-bit products, closed on last    |
// | or at MAX_TERMS and held until acknowledged.                             |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module mac_accumulator #(
  parameter int ACC_W     = 20,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mac_accumulator_if.slave    bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ACCUM = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_TERMS);
  localparam logic [ACC_W-1:0] c_ACC_MAX = {ACC_W{1'b1}};

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_accum;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_accept;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_sat;
  logic [CNT_W-1:0] w_next_count;
  logic             w_close;

  assign w_accept     = bus.valid && (r_state != c_DONE);
  assign w_base       = (r_state == c_IDLE) ? '0 : r_accum;
  // One guard bit above the accumulator exposes the carry used for saturation.
  assign w_sum        = {1'b0, w_base} + {{(ACC_W - 15){1'b0}}, bus.product};
  assign w_sat        = w_sum[ACC_W];
  assign w_next_count = (r_state == c_IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
  assign w_close      = bus.last || (w_next_count == c_MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_accum    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_state    <= c_IDLE;
      r_accum    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_ACCUM: begin
          if (w_accept) begin
            r_accum    <= w_sat ? c_ACC_MAX : w_sum[ACC_W-1:0];
            r_count    <= w_next_count;
            r_overflow <= (r_state == c_ACCUM) ? (r_overflow | w_sat) : w_sat;
            r_state    <= w_close ? c_DONE : c_ACCUM;
          end
        end
        c_DONE: begin
          if (bus.ack) begin
            r_state    <= c_IDLE;
            r_accum    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
        default: begin
          r_state    <= c_IDLE;
          r_accum    <= '0;
          r_count    <= '0;
          r_overflow <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = (r_state != c_DONE);
  assign bus.done     = (r_state == c_DONE);
  assign bus.accum    = r_accum;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// | tb_mac_accumulator                                                       |
// | Directed self-checking bench for mac_accumulator (ACC_W 20 and 16).      |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mac_accumulator;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mac_accumulator_if #(.ACC_W(20), .CNT_W(5)) bus0 ();
  mac_accumulator_if #(.ACC_W(16), .CNT_W(5)) bus1 ();

  mac_accumulator #(.ACC_W(20), .MAX_TERMS(16), .CNT_W(5)) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mac_accumulator #(.ACC_W(16), .MAX_TERMS(16), .CNT_W(5)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus0.product = '0; bus0.valid = 1'b0; bus0.last = 1'b0; bus0.clear = 1'b0; bus0.ack = 1'b0;
    bus1.product = '0; bus1.valid = 1'b0; bus1.last = 1'b0; bus1.clear = 1'b0; bus1.ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_accum", 32'(bus0.accum), 0);
    chk("rst_count", 32'(bus0.count), 0);
    chk("rst_done", 32'(bus0.done), 0);
    chk("rst_ovf", 32'(bus0.overflow), 0);
    chk("rst_ready", 32'(bus0.ready), 1);

    // Three terms closed by last
    bus0.valid = 1'b1; bus0.product = 16'd6;
    tick();
    chk("t1_accum1", 32'(bus0.accum), 6);
    chk("t1_count1", 32'(bus0.count), 1);
    bus0.product = 16'd15;
    tick();
    chk("t1_accum2", 32'(bus0.accum), 21);
    bus0.product = 16'd225; bus0.last = 1'b1;
    tick();
    bus0.valid = 1'b0; bus0.last = 1'b0;
    chk("t1_accum3", 32'(bus0.accum), 246);
    chk("t1_count3", 32'(bus0.count), 3);
    chk("t1_done", 32'(bus0.done), 1);
    chk("t1_ready", 32'(bus0.ready), 0);
    bus0.ack = 1'b1;
    tick();
    bus0.ack = 1'b0;
    chk("t1_ack_done", 32'(bus0.done), 0);
    chk("t1_ack_accum", 32'(bus0.accum), 0);
    chk("t1_ack_count", 32'(bus0.count), 0);
    chk("t1_ack_ready", 32'(bus0.ready), 1);

    // Sixteen terms close automatically
    bus0.valid = 1'b1; bus0.product = 16'd225;
    for (int i = 0; i < 15; i++) tick();
    chk("t2_done15", 32'(bus0.done), 0);
    tick();
    chk("t2_done", 32'(bus0.done), 1);
    chk("t2_accum", 32'(bus0.accum), 3600);
    chk("t2_count", 32'(bus0.count), 16);
    chk("t2_ready17", 32'(bus0.ready), 0);
    tick();
    chk("t2_accum17", 32'(bus0.accum), 3600);
    chk("t2_count17", 32'(bus0.count), 16);
    bus0.valid = 1'b0; bus0.ack = 1'b1;
    tick();
    bus0.ack = 1'b0;

    // Saturation on the 16-bit instance
    bus1.valid = 1'b1; bus1.product = 16'hFFFF;
    tick();
    chk("t3_accum1", 32'(bus1.accum), 32'hFFFF);
    chk("t3_ovf1", 32'(bus1.overflow), 0);
    tick();
    chk("t3_accum2", 32'(bus1.accum), 32'hFFFF);
    chk("t3_ovf2", 32'(bus1.overflow), 1);
    for (int i = 0; i < 14; i++) tick();
    bus1.valid = 1'b0;
    chk("t3_accum16", 32'(bus1.accum), 32'hFFFF);
    chk("t3_ovf16", 32'(bus1.overflow), 1);
    chk("t3_count16", 32'(bus1.count), 16);
    chk("t3_done", 32'(bus1.done), 1);
    bus1.ack = 1'b1;
    tick();
    bus1.ack = 1'b0;
    chk("t3_ack_ovf", 32'(bus1.overflow), 0);

    // Clear with a simultaneous term while accumulating
    bus0.valid = 1'b1; bus0.product = 16'd15;
    tick();
    bus0.product = 16'd25;
    tick();
    bus0.valid = 1'b0; bus0.last = 1'b1;
    tick();
    bus0.last = 1'b0;
    chk("t4_accum40", 32'(bus0.accum), 40);
    chk("t4_last_no_valid", 32'(bus0.done), 0);
    bus0.valid = 1'b1; bus0.product = 16'd9; bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0; bus0.valid = 1'b0;
    chk("t4_clr_accum", 32'(bus0.accum), 0);
    chk("t4_clr_count", 32'(bus0.count), 0);
    chk("t4_clr_ready", 32'(bus0.ready), 1);
    bus0.valid = 1'b1; bus0.product = 16'd5;
    tick();
    chk("t4_fresh_accum", 32'(bus0.accum), 5);
    chk("t4_fresh_count", 32'(bus0.count), 1);
    bus0.valid = 1'b0; bus0.clear = 1'b1;
    tick();
    bus0.clear = 1'b0;

    // DONE ignores valid, then resumes after ack
    bus0.valid = 1'b1; bus0.product = 16'd10; bus0.last = 1'b1;
    tick();
    bus0.last = 1'b0;
    chk("t5_done", 32'(bus0.done), 1);
    for (int i = 0; i < 5; i++) begin
      bus0.product = 16'($urandom_range(0, 65535));
      tick();
      chk("t5_hold_accum", 32'(bus0.accum), 10);
      chk("t5_hold_count", 32'(bus0.count), 1);
    end
    bus0.valid = 1'b0; bus0.ack = 1'b1;
    tick();
    bus0.ack = 1'b0;
    bus0.valid = 1'b1; bus0.product = 16'd7;
    tick();
    chk("t5_next_accum", 32'(bus0.accum), 7);
    chk("t5_next_count", 32'(bus0.count), 1);

    // Asynchronous reset between edges
    bus0.product = 16'd93;
    tick();
    bus0.valid = 1'b0;
    chk("t6_accum100", 32'(bus0.accum), 100);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_accum", 32'(bus0.accum), 0);
    chk("t6_async_count", 32'(bus0.count), 0);
    rst = 1'b0;
    tick();
    chk("t6_ready", 32'(bus0.ready), 1);
    chk("t6_accum_after", 32'(bus0.accum), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
